// File: rtl/param_datapath_pkg.sv
// Purpose: shared types, status bit positions and the combined shifter/ALU function for param_datapath_seq.
// Latency: purely combinational helpers with no state.
// Backpressure: not applicable.
package param_datapath_pkg;

  localparam int STATUS_W = 3;
  localparam int ST_Z     = 0;
  localparam int ST_N     = 1;
  localparam int ST_V     = 2;
  // Widest datapath the exec function handles; narrower datapaths are masked down to WIDTH.
  localparam int MAXW     = 32;

  typedef enum logic [1:0] {ALU_ADD = 2'b00, ALU_SUB = 2'b01, ALU_AND = 2'b10, ALU_NOT = 2'b11} alu_op_e;
  typedef enum logic [1:0] {SH_NONE = 2'b00, SH_LSL1 = 2'b01, SH_LSR1 = 2'b10, SH_ASR1 = 2'b11} shift_e;
  typedef enum logic [1:0] {VS_C = 2'b00, VS_MDATA = 2'b01, VS_IMM8 = 2'b10, VS_RSVD = 2'b11} vsel_e;
  typedef enum logic [2:0] {S_IDLE, S_READA, S_READB, S_EXEC, S_WB} state_e;

  typedef struct packed {
    logic [MAXW-1:0]     c;
    logic [STATUS_W-1:0] st;
  } exec_res_t;

  // Operand select, B shifter and ALU for a w-bit datapath carried in MAXW-bit containers.
  // All results are masked to w bits, so the upper container bits are always zero.
  function automatic exec_res_t dp_exec(input logic [MAXW-1:0] a, input logic [MAXW-1:0] b,
                                        input logic [MAXW-1:0] imm5, input logic asel,
                                        input logic bsel, input shift_e sh, input alu_op_e op,
                                        input int unsigned w);
    logic [MAXW-1:0] one, mask, top, ain, bsh, bin, r;
    logic            sa, sb, sr, v;
    exec_res_t       res;
    one  = {{(MAXW-1){1'b0}}, 1'b1};
    mask = (one << w) - one;
    top  = one << (w - 1);
    case (sh)
      SH_LSL1: bsh = (b << 1) & mask;
      SH_LSR1: bsh = (b & mask) >> 1;
      SH_ASR1: bsh = ((b & mask) >> 1) | (b & top);
      default: bsh = b & mask;
    endcase
    ain = asel ? '0 : (a & mask);
    bin = bsel ? (imm5 & mask) : bsh;
    case (op)
      ALU_ADD: r = (ain + bin) & mask;
      ALU_SUB: r = (ain - bin) & mask;
      ALU_AND: r = ain & bin;
      default: r = (~bin) & mask;
    endcase
    sa = |(ain & top);
    sb = |(bin & top);
    sr = |(r & top);
    case (op)
      ALU_ADD: v = (sa == sb) && (sr != sa);
      ALU_SUB: v = (sa != sb) && (sr != sa);
      default: v = 1'b0;
    endcase
    res.c        = r;
    res.st       = '0;
    res.st[ST_Z] = (r == '0);
    res.st[ST_N] = sr;
    res.st[ST_V] = v;
    return res;
  endfunction

endpackage

// File: rtl/regfile_n.sv
// Purpose: NREGS x WIDTH register file, one synchronous write port and one combinational read port.
// Latency: write visible on the read port the cycle after the write edge; read is same-cycle.
// Backpressure: none, always accepts a write.
module regfile_n #(
  parameter int WIDTH = 16,
  parameter int NREGS = 8,
  localparam int RIDX = $clog2(NREGS)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             we_i,
  input  logic [RIDX-1:0]  waddr_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic [RIDX-1:0]  raddr_i,
  output logic [WIDTH-1:0] rdata_o
);

  logic [WIDTH-1:0] regs_q [NREGS];

  // Storage: cleared on reset, written on enabled edges.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
    end else if (we_i) begin
      regs_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = regs_q[raddr_i];

endmodule

// File: rtl/param_datapath_seq.sv
// Purpose: sequenced datapath running each command through READA -> READB -> EXEC -> WB.
// Latency: done pulses four cycles after the accepting cycle; result readable from the edge after done.
// Backpressure: cmd_ready only in IDLE; commands offered while busy are dropped, never queued.
module param_datapath_seq
  import param_datapath_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int NREGS = 8,
  localparam int RIDX = $clog2(NREGS)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic [RIDX-1:0]     cmd_rn,
  input  logic [RIDX-1:0]     cmd_rm,
  input  logic [RIDX-1:0]     cmd_rd,
  input  logic [1:0]          cmd_shift,
  input  logic [1:0]          cmd_aluop,
  input  logic                cmd_asel,
  input  logic                cmd_bsel,
  input  logic [1:0]          cmd_vsel,
  input  logic                cmd_wen,
  input  logic                cmd_loads,
  input  logic [WIDTH-1:0]    mdata,
  input  logic [WIDTH-1:0]    sximm5,
  input  logic [WIDTH-1:0]    sximm8,
  output logic [STATUS_W-1:0] status,
  output logic [WIDTH-1:0]    datapath_out,
  output logic                done
);

  state_e              state_q, state_d;
  logic [RIDX-1:0]     rn_q, rm_q, rd_q;
  shift_e              sh_q;
  alu_op_e             op_q;
  vsel_e               vsel_q;
  logic                asel_q, bsel_q, wen_q, loads_q;
  logic [WIDTH-1:0]    a_q, b_q, c_q;
  logic [STATUS_W-1:0] status_q;
  logic [WIDTH-1:0]    rf_rdata, wb_data;
  logic [RIDX-1:0]     rf_raddr;
  logic                rf_we;
  exec_res_t           ex;

  // The single read port serves rn in READA and rm otherwise (only READB consumes it).
  assign rf_raddr = (state_q == S_READA) ? rn_q : rm_q;

  regfile_n #(.WIDTH(WIDTH), .NREGS(NREGS)) u_rf (
    .clk_i   (clk),
    .rst_i   (reset),
    .we_i    (rf_we),
    .waddr_i (rd_q),
    .wdata_i (wb_data),
    .raddr_i (rf_raddr),
    .rdata_o (rf_rdata)
  );

  assign ex = dp_exec(MAXW'(a_q), MAXW'(b_q), MAXW'(sximm5), asel_q, bsel_q, sh_q, op_q, WIDTH);

  // Container bits above WIDTH are always zero after masking.
  if (WIDTH < MAXW) begin : g_pad
    logic unused_hi;
    assign unused_hi = ^ex.c[MAXW-1:WIDTH];
  end

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Next-state and per-state strobes.
  always_comb begin
    state_d   = state_q;
    cmd_ready = 1'b0;
    done      = 1'b0;
    rf_we     = 1'b0;
    case (state_q)
      S_IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) state_d = S_READA;
      end
      S_READA: state_d = S_READB;
      S_READB: state_d = S_EXEC;
      S_EXEC:  state_d = S_WB;
      S_WB: begin
        done    = 1'b1;
        rf_we   = wen_q;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Writeback source; the reserved code falls back to C.
  always_comb begin
    wb_data = c_q;
    case (vsel_q)
      VS_MDATA: wb_data = mdata;
      VS_IMM8:  wb_data = sximm8;
      default:  wb_data = c_q;
    endcase
  end

  // Command register, loaded on the accepting edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rn_q    <= '0;
      rm_q    <= '0;
      rd_q    <= '0;
      sh_q    <= SH_NONE;
      op_q    <= ALU_ADD;
      vsel_q  <= VS_C;
      asel_q  <= 1'b0;
      bsel_q  <= 1'b0;
      wen_q   <= 1'b0;
      loads_q <= 1'b0;
    end else if (state_q == S_IDLE && cmd_valid) begin
      rn_q    <= cmd_rn;
      rm_q    <= cmd_rm;
      rd_q    <= cmd_rd;
      sh_q    <= shift_e'(cmd_shift);
      op_q    <= alu_op_e'(cmd_aluop);
      vsel_q  <= vsel_e'(cmd_vsel);
      asel_q  <= cmd_asel;
      bsel_q  <= cmd_bsel;
      wen_q   <= cmd_wen;
      loads_q <= cmd_loads;
    end
  end

  // Operand and result registers; C always loads in EXEC, status only when requested.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      a_q      <= '0;
      b_q      <= '0;
      c_q      <= '0;
      status_q <= '0;
    end else begin
      if (state_q == S_READA) a_q <= rf_rdata;
      if (state_q == S_READB) b_q <= rf_rdata;
      if (state_q == S_EXEC) begin
        c_q <= ex.c[WIDTH-1:0];
        if (loads_q) status_q <= ex.st;
      end
    end
  end

  assign status       = status_q;
  assign datapath_out = c_q;

endmodule

// File: tb/tb_param_datapath_seq.sv
// Purpose: directed self-checking bench for param_datapath_seq at 16x8 and 8x4.
// Latency: checks done four cycles after the accepting cycle.
// Backpressure: checks that commands offered while busy are dropped.
module tb_param_datapath_seq;

  logic        clk, reset, v16, v8;
  logic [2:0]  rn, rm, rd;
  logic [1:0]  sh, op, vsel;
  logic        asel, bsel, wen, loads;
  logic [15:0] imm5, imm8, md;
  logic        rdy16, done16, rdy8, done8;
  logic [2:0]  st16, st8;
  logic [15:0] dout16;
  logic [7:0]  dout8;

  int          total = 0;
  int          bad   = 0;
  logic [15:0] c;
  logic [2:0]  st;
  int          acc, first, second;

  param_datapath_seq #(.WIDTH(16), .NREGS(8)) dut16 (
    .clk(clk), .reset(reset), .cmd_valid(v16), .cmd_ready(rdy16),
    .cmd_rn(rn), .cmd_rm(rm), .cmd_rd(rd), .cmd_shift(sh), .cmd_aluop(op),
    .cmd_asel(asel), .cmd_bsel(bsel), .cmd_vsel(vsel), .cmd_wen(wen), .cmd_loads(loads),
    .mdata(md), .sximm5(imm5), .sximm8(imm8),
    .status(st16), .datapath_out(dout16), .done(done16)
  );

  param_datapath_seq #(.WIDTH(8), .NREGS(4)) dut8 (
    .clk(clk), .reset(reset), .cmd_valid(v8), .cmd_ready(rdy8),
    .cmd_rn(rn[1:0]), .cmd_rm(rm[1:0]), .cmd_rd(rd[1:0]), .cmd_shift(sh), .cmd_aluop(op),
    .cmd_asel(asel), .cmd_bsel(bsel), .cmd_vsel(vsel), .cmd_wen(wen), .cmd_loads(loads),
    .mdata(md[7:0]), .sximm5(imm5[7:0]), .sximm8(imm8[7:0]),
    .status(st8), .datapath_out(dout8), .done(done8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not reach the summary");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Issue one command to the selected DUT (sel=1: 8-bit instance), wait for done,
  // check its latency and return C and status as seen during WB.
  task automatic do_cmd(input string tag, input bit sel,
                        input logic [2:0] t_rn, input logic [2:0] t_rm, input logic [2:0] t_rd,
                        input logic [1:0] t_sh, input logic [1:0] t_op,
                        input logic t_asel, input logic t_bsel, input logic [1:0] t_vsel,
                        input logic t_wen, input logic t_loads,
                        input logic [15:0] t_imm5, input logic [15:0] t_imm8, input logic [15:0] t_md,
                        output logic [15:0] oc, output logic [2:0] ost);
    int lat, wt;
    wt = 0;
    @(negedge clk);
    while (!(sel ? rdy8 : rdy16) && wt < 20) begin
      @(negedge clk);
      wt++;
    end
    rn = t_rn; rm = t_rm; rd = t_rd; sh = t_sh; op = t_op;
    asel = t_asel; bsel = t_bsel; vsel = t_vsel; wen = t_wen; loads = t_loads;
    imm5 = t_imm5; imm8 = t_imm8; md = t_md;
    if (sel) v8 = 1'b1; else v16 = 1'b1;
    @(posedge clk);
    #1;
    v8 = 1'b0;
    v16 = 1'b0;
    // Counting the accepting cycle as cycle t, done is up three edges later (cycle t+4).
    lat = 0;
    for (int k = 1; k <= 8; k++) begin
      @(posedge clk);
      #1;
      if (sel ? done8 : done16) begin
        lat = k;
        break;
      end
    end
    chk({tag, "_lat"}, lat, 3);
    oc  = sel ? {8'h00, dout8} : dout16;
    ost = sel ? st8 : st16;
  endtask

  task automatic wr_imm(input string tag, input bit sel, input logic [2:0] r, input logic [15:0] val);
    logic [15:0] oc;
    logic [2:0]  ost;
    do_cmd(tag, sel, 3'd0, 3'd0, r, 2'b00, 2'b00, 1'b1, 1'b1, 2'b10, 1'b1, 1'b0,
           16'h0, val, 16'h0, oc, ost);
  endtask

  // C = 0 + R[r], no writeback, status untouched.
  task automatic rd_reg(input string tag, input bit sel, input logic [2:0] r, output logic [15:0] val);
    logic [2:0] ost;
    do_cmd(tag, sel, 3'd0, r, 3'd0, 2'b00, 2'b00, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0,
           16'h0, 16'h0, 16'h0, val, ost);
  endtask

  initial begin
    reset = 1'b1; v16 = 1'b0; v8 = 1'b0;
    rn = '0; rm = '0; rd = '0; sh = '0; op = '0; vsel = '0;
    asel = 1'b0; bsel = 1'b0; wen = 1'b0; loads = 1'b0;
    imm5 = '0; imm8 = '0; md = '0;
    repeat (2) @(negedge clk);
    reset = 1'b0;

    // 1: reset while a write to R1 is in EXEC.
    do_cmd("t1pre", 0, 3'd0, 3'd0, 3'd1, 2'b00, 2'b00, 1'b1, 1'b1, 2'b10, 1'b1, 1'b1,
           16'h8000, 16'h0005, 16'h0, c, st);
    chk("t1pre_c", c, 16'h8000);
    chk("t1pre_st", st, 3'b010);
    @(negedge clk);
    rn = 3'd0; rm = 3'd0; rd = 3'd1; sh = 2'b00; op = 2'b00;
    asel = 1'b1; bsel = 1'b1; vsel = 2'b10; wen = 1'b1; loads = 1'b1;
    imm5 = 16'h0003; imm8 = 16'h0009;
    @(negedge clk);
    while (!rdy16) @(negedge clk);
    v16 = 1'b1;
    @(posedge clk);
    #1;
    v16 = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #3;
    reset = 1'b1;
    #1;
    chk("t1_rdy", rdy16, 1'b1);
    chk("t1_st", st16, 3'b000);
    chk("t1_done", done16, 1'b0);
    chk("t1_c", dout16, 16'h0000);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    rd_reg("t1rd", 0, 3'd1, c);
    chk("t1_r1", c, 16'h0000);

    // 2: R0 = 7, then R2 = R0 + (R0 LSL1).
    wr_imm("t2w", 0, 3'd0, 16'h0007);
    do_cmd("t2add", 0, 3'd0, 3'd0, 3'd2, 2'b01, 2'b00, 1'b0, 1'b0, 2'b00, 1'b1, 1'b1,
           16'h0, 16'h0, 16'h0, c, st);
    chk("t2_c", c, 16'h0015);
    chk("t2_st", st, 3'b000);
    rd_reg("t2rd", 0, 3'd2, c);
    chk("t2_r2", c, 16'h0015);

    // 3: signed overflow on ADD.
    wr_imm("t3w3", 0, 3'd3, 16'h7FFF);
    wr_imm("t3w4", 0, 3'd4, 16'h0001);
    do_cmd("t3add", 0, 3'd3, 3'd4, 3'd0, 2'b00, 2'b00, 1'b0, 1'b0, 2'b00, 1'b0, 1'b1,
           16'h0, 16'h0, 16'h0, c, st);
    chk("t3_c", c, 16'h8000);
    chk("t3_st", st, 3'b110);

    // Immediate B operand: 7 - (-16) = 23.
    do_cmd("timm", 0, 3'd0, 3'd0, 3'd0, 2'b00, 2'b01, 1'b0, 1'b1, 2'b00, 1'b0, 1'b1,
           16'hFFF0, 16'h0, 16'h0, c, st);
    chk("timm_c", c, 16'h0017);
    chk("timm_st", st, 3'b000);

    // 4: SUB to zero, then AND without loads keeps status.
    do_cmd("t4sub", 0, 3'd3, 3'd3, 3'd0, 2'b00, 2'b01, 1'b0, 1'b0, 2'b00, 1'b0, 1'b1,
           16'h0, 16'h0, 16'h0, c, st);
    chk("t4sub_c", c, 16'h0000);
    chk("t4sub_st", st, 3'b001);
    do_cmd("t4and", 0, 3'd3, 3'd4, 3'd0, 2'b00, 2'b10, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0,
           16'h0, 16'h0, 16'h0, c, st);
    chk("t4and_c", c, 16'h0001);
    chk("t4and_st", st, 3'b001);

    // 5: cmd_valid held 10 cycles, rd = cycle index, write 0xAA.
    @(posedge clk);
    acc = 0; first = -1; second = -1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      rn = 3'd0; rm = 3'd0; rd = 3'(i); sh = 2'b00; op = 2'b00;
      asel = 1'b1; bsel = 1'b1; vsel = 2'b10; wen = 1'b1; loads = 1'b0;
      imm8 = 16'h00AA;
      v16 = 1'b1;
      if (rdy16) begin
        acc++;
        if (first < 0) first = i;
        else second = i;
      end
    end
    @(negedge clk);
    v16 = 1'b0;
    chk("t5_acc", acc, 2);
    chk("t5_first", first, 0);
    chk("t5_gap", second - first, 5);
    rd_reg("t5r0", 0, 3'd0, c);
    chk("t5_r0", c, 16'h00AA);
    rd_reg("t5r5", 0, 3'd5, c);
    chk("t5_r5", c, 16'h00AA);
    rd_reg("t5r1", 0, 3'd1, c);
    chk("t5_r1", c, 16'h0000);
    rd_reg("t5r4", 0, 3'd4, c);
    chk("t5_r4", c, 16'h0001);

    // 6: 8-bit, 4-register instance.
    wr_imm("t6w3", 1, 3'd3, 16'h0080);
    do_cmd("t6asr", 1, 3'd0, 3'd3, 3'd2, 2'b11, 2'b00, 1'b1, 1'b0, 2'b00, 1'b1, 1'b1,
           16'h0, 16'h0, 16'h0, c, st);
    chk("t6asr_c", c, 16'h00C0);
    chk("t6asr_st", st, 3'b010);
    do_cmd("t6not", 1, 3'd0, 3'd2, 3'd0, 2'b00, 2'b11, 1'b0, 1'b0, 2'b00, 1'b0, 1'b1,
           16'h0, 16'h0, 16'h0, c, st);
    chk("t6not_c", c, 16'h003F);
    chk("t6not_st", st, 3'b000);
    do_cmd("t6md", 1, 3'd0, 3'd0, 3'd1, 2'b00, 2'b00, 1'b1, 1'b0, 2'b01, 1'b1, 1'b0,
           16'h0, 16'h0, 16'h00A5, c, st);
    rd_reg("t6r1", 1, 3'd1, c);
    chk("t6_r1", c, 16'h00A5);
    do_cmd("t6lsr", 1, 3'd0, 3'd3, 3'd0, 2'b10, 2'b00, 1'b1, 1'b0, 2'b00, 1'b0, 1'b1,
           16'h0, 16'h0, 16'h0, c, st);
    chk("t6lsr_c", c, 16'h0040);
    chk("t6lsr_st", st, 3'b000);
    do_cmd("t6lsl", 1, 3'd0, 3'd3, 3'd0, 2'b01, 2'b00, 1'b1, 1'b0, 2'b00, 1'b0, 1'b1,
           16'h0, 16'h0, 16'h0, c, st);
    chk("t6lsl_c", c, 16'h0000);
    chk("t6lsl_st", st, 3'b001);
    do_cmd("t6ovf", 1, 3'd3, 3'd3, 3'd0, 2'b00, 2'b00, 1'b0, 1'b0, 2'b00, 1'b0, 1'b1,
           16'h0, 16'h0, 16'h0, c, st);
    chk("t6ovf_c", c, 16'h0000);
    chk("t6ovf_st", st, 3'b101);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
